// File: rtl/umi_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : umi_regfile_pkg
// Purpose  : Shared definitions for the umi_regfile register bank:
//            response error codes and the access FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package umi_regfile_pkg;

  // Response codes returned on reg_err alongside reg_ready
  localparam logic [1:0] ERR_OK     = 2'b00;
  localparam logic [1:0] ERR_SLVERR = 2'b10;
  localparam logic [1:0] ERR_DECERR = 2'b11;

  // Access FSM: one decode/execute cycle followed by one acknowledge cycle
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

endpackage : umi_regfile_pkg
`default_nettype wire

// File: rtl/umi_regfile_dec.sv
`default_nettype none
// ============================================================================
// Module   : umi_regfile_dec
// Purpose  : Combinational decode of a register access: word index, a
//            read-only-region flag and the prioritised error code.
// Ports    : i_addr  - byte address
//            i_read  - read request
//            i_write - write request
//            i_prot  - protection attributes, bit0 = privileged
//            o_idx   - word index
//            o_ro    - index falls in the read-only status region
//            o_err   - response code (OK / SLVERR / DECERR)
// Config   : UMI_REGFILE_PROT_EN - when defined, unprivileged writes to the
//            upper half of the register space are rejected with SLVERR.
// Revision : 1.0 - initial release
// ============================================================================
module umi_regfile_dec
  import umi_regfile_pkg::*;
#(
  parameter int AW     = 64,
  parameter int REGS   = 512,
  parameter int ROREGS = 4
) (
  input  logic [AW-1:0]            i_addr,
  input  logic                     i_read,
  input  logic                     i_write,
  input  logic [1:0]               i_prot,
  output logic [$clog2(REGS)-1:0]  o_idx,
  output logic                     o_ro,
  output logic [1:0]               o_err
);

  localparam int          IW   = $clog2(REGS);
  localparam logic [IW:0] C_RO = (IW+1)'(ROREGS);

  logic w_hi_bits;
  logic w_unused_prot;

  assign o_idx     = i_addr[2 +: IW];
  assign o_ro      = ({1'b0, o_idx} < C_RO);
  // Any address bit above the decoded word range selects nothing here
  assign w_hi_bits = |(i_addr >> (2 + IW));
  // Only prot[0] carries meaning, and only when protection is built in
  assign w_unused_prot = ^i_prot;

  always_comb begin
    o_err = ERR_OK;
    if (w_hi_bits) begin
      o_err = ERR_DECERR;
    end else if (i_read && i_write) begin
      o_err = ERR_SLVERR;
    end else if (i_addr[1:0] != 2'b00) begin
      o_err = ERR_SLVERR;
    end else if (i_write && o_ro) begin
      o_err = ERR_SLVERR;
    end
`ifdef UMI_REGFILE_PROT_EN
    // Upper half of the index space (MSB of index set) is privileged-write
    else if (i_write && !i_prot[0] && o_idx[IW-1]) begin
      o_err = ERR_SLVERR;
    end
`endif
  end

endmodule : umi_regfile_dec
`default_nettype wire

// File: rtl/umi_regfile.sv
`default_nettype none
// ============================================================================
// Module   : umi_regfile
// Purpose  : Memory-mapped register bank terminating a simple register
//            interface. One access per handshake, registered read data with
//            a single-cycle reg_ready acknowledge and error code. The lowest
//            ROREGS words mirror hw_status; the rest are read-write and are
//            exported flat on hw_regs with a write-notify pulse.
// Ports    : clk, reset (async, active-high)
//            reg_write/reg_read/reg_addr/reg_wrdata/reg_prot - request
//            reg_rddata/reg_ready/reg_err                    - response
//            hw_status - status word i at [i*RW +: RW]
//            hw_regs   - read-write words ROREGS..REGS-1, lowest first
//            hw_wr / hw_wr_idx - write notify pulse and last written index
// Config   : UMI_REGFILE_PROT_EN - see umi_regfile_dec.
// Revision : 1.0 - initial release
// ============================================================================
module umi_regfile
  import umi_regfile_pkg::*;
#(
  parameter int RW     = 32,
  parameter int AW     = 64,
  parameter int REGS   = 512,
  parameter int ROREGS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      reg_write,
  input  logic                      reg_read,
  input  logic [AW-1:0]             reg_addr,
  input  logic [RW-1:0]             reg_wrdata,
  input  logic [1:0]                reg_prot,
  output logic [RW-1:0]             reg_rddata,
  output logic                      reg_ready,
  output logic [1:0]                reg_err,
  input  logic [ROREGS*RW-1:0]      hw_status,
  output logic [(REGS-ROREGS)*RW-1:0] hw_regs,
  output logic                      hw_wr,
  output logic [$clog2(REGS)-1:0]   hw_wr_idx
);

  localparam int IW = $clog2(REGS);

  logic [IW-1:0] w_idx;
  logic          w_ro;
  logic [1:0]    w_err;
  logic          w_req;
  logic          w_ok;
  logic [RW-1:0] w_stat_word;
  logic [RW-1:0] w_rd_word;

  state_t        r_state;
  logic          r_ready;
  logic [1:0]    r_err;
  logic [RW-1:0] r_rddata;
  logic          r_hw_wr;
  logic [IW-1:0] r_wr_idx;
  // Full-depth array keeps indexing direct; the low ROREGS entries are never
  // written and stay at their reset value.
  logic [RW-1:0] r_mem [REGS];

  umi_regfile_dec #(
    .AW     (AW),
    .REGS   (REGS),
    .ROREGS (ROREGS)
  ) u_dec (
    .i_addr  (reg_addr),
    .i_read  (reg_read),
    .i_write (reg_write),
    .i_prot  (reg_prot),
    .o_idx   (w_idx),
    .o_ro    (w_ro),
    .o_err   (w_err)
  );

  assign w_req = reg_read | reg_write;
  assign w_ok  = (w_err == ERR_OK);

  // Select the addressed status word without an out-of-range part-select
  always_comb begin
    w_stat_word = '0;
    for (int i = 0; i < ROREGS; i++) begin
      if (w_idx == IW'(i)) begin
        w_stat_word = hw_status[i*RW +: RW];
      end
    end
  end

  assign w_rd_word = w_ro ? w_stat_word : r_mem[w_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_ready  <= 1'b0;
      r_err    <= ERR_OK;
      r_rddata <= '0;
      r_hw_wr  <= 1'b0;
      r_wr_idx <= '0;
      for (int i = 0; i < REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_state  <= ST_ACK;
            r_ready  <= 1'b1;
            r_err    <= w_err;
            r_rddata <= (w_ok && reg_read) ? w_rd_word : '0;
            // An OK access is never both read and write, so this is a pure write
            if (w_ok && reg_write) begin
              r_mem[w_idx] <= reg_wrdata;
              r_hw_wr      <= 1'b1;
              r_wr_idx     <= w_idx;
            end
          end
        end
        ST_ACK: begin
          // Requests are ignored here; a held request is taken next IDLE cycle
          r_state  <= ST_IDLE;
          r_ready  <= 1'b0;
          r_err    <= ERR_OK;
          r_rddata <= '0;
          r_hw_wr  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < REGS - ROREGS; gi++) begin : g_hw_regs
      assign hw_regs[gi*RW +: RW] = r_mem[gi + ROREGS];
    end
  endgenerate

  assign reg_ready  = r_ready;
  assign reg_err    = r_err;
  assign reg_rddata = r_rddata;
  assign hw_wr      = r_hw_wr;
  assign hw_wr_idx  = r_wr_idx;

endmodule : umi_regfile
`default_nettype wire

// File: tb/tb_umi_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_umi_regfile
// Purpose  : Self-checking bench for umi_regfile. A driver issues accesses and
//            pushes the response predicted by an array-based reference model
//            into a queue; a monitor pops and compares on every reg_ready.
// Revision : 1.0 - initial release
// ============================================================================
module tb_umi_regfile;

  localparam int RW     = 32;
  localparam int AW     = 64;
  localparam int REGS   = 512;
  localparam int ROREGS = 4;
  localparam int IW     = 9;

  logic                        clk;
  logic                        reset;
  logic                        reg_write;
  logic                        reg_read;
  logic [AW-1:0]               reg_addr;
  logic [RW-1:0]               reg_wrdata;
  logic [1:0]                  reg_prot;
  logic [RW-1:0]               reg_rddata;
  logic                        reg_ready;
  logic [1:0]                  reg_err;
  logic [ROREGS*RW-1:0]        hw_status;
  logic [(REGS-ROREGS)*RW-1:0] hw_regs;
  logic                        hw_wr;
  logic [IW-1:0]               hw_wr_idx;

  umi_regfile #(
    .RW(RW), .AW(AW), .REGS(REGS), .ROREGS(ROREGS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .reg_write  (reg_write),
    .reg_read   (reg_read),
    .reg_addr   (reg_addr),
    .reg_wrdata (reg_wrdata),
    .reg_prot   (reg_prot),
    .reg_rddata (reg_rddata),
    .reg_ready  (reg_ready),
    .reg_err    (reg_err),
    .hw_status  (hw_status),
    .hw_regs    (hw_regs),
    .hw_wr      (hw_wr),
    .hw_wr_idx  (hw_wr_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] rd;
    logic [1:0]    err;
    logic          wr;
    logic [IW-1:0] widx;
    int            chk_idx;
    logic [RW-1:0] chk_val;
  } exp_t;

  exp_t          q[$];
  logic [RW-1:0] model [REGS];
  logic [IW-1:0] last_idx;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < REGS; i++) model[i] = '0;
    last_idx = '0;
  endtask

  // Predict the response from the address map rules, then drive the request
  // until acknowledged.
  task automatic access(input logic rd, input logic wr, input logic [AW-1:0] addr,
                        input logic [RW-1:0] data, input logic [1:0] prot, input bit push);
    exp_t       e;
    int         idx;
    logic [1:0] err;
    bit         got;
    idx = int'(addr[2 +: IW]);
    if ((addr >> (2 + IW)) != 0)            err = 2'b11;
    else if (rd && wr)                      err = 2'b10;
    else if (addr[1:0] != 2'b00)            err = 2'b10;
    else if (wr && idx < ROREGS)            err = 2'b10;
`ifdef UMI_REGFILE_PROT_EN
    else if (wr && !prot[0] && idx >= REGS/2) err = 2'b10;
`endif
    else                                    err = 2'b00;
    e.err = err;
    e.rd  = '0;
    e.wr  = 1'b0;
    if (err == 2'b00 && rd)
      e.rd = (idx < ROREGS) ? hw_status[idx*RW +: RW] : model[idx];
    if (err == 2'b00 && wr) begin
      model[idx] = data;
      last_idx   = IW'(idx);
      e.wr       = 1'b1;
    end
    e.widx    = last_idx;
    e.chk_idx = (idx >= ROREGS) ? idx : -1;
    e.chk_val = model[idx];
    if (push) q.push_back(e);

    reg_read   = rd;
    reg_write  = wr;
    reg_addr   = addr;
    reg_wrdata = data;
    reg_prot   = prot;
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (reg_ready) begin
        got = 1'b1;
        break;
      end
    end
    reg_read  = 1'b0;
    reg_write = 1'b0;
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL ack_timeout: got no reg_ready, expected one for addr %h", addr);
      if (push) void'(q.pop_back());
    end
  endtask

  // Monitor: every acknowledge consumes exactly one prediction
  logic prev_rdy = 1'b0;
  exp_t me;
  initial begin
    forever begin
      @(negedge clk);
      if (reg_ready) begin
        chk("ready_single_cycle", {63'd0, prev_rdy}, 64'd0);
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_ready: got reg_ready=1, expected no response");
        end else begin
          me = q.pop_front();
          chk("rddata", 64'(reg_rddata), 64'(me.rd));
          chk("err", 64'(reg_err), 64'(me.err));
          chk("hw_wr", 64'(hw_wr), 64'(me.wr));
          chk("hw_wr_idx", 64'(hw_wr_idx), 64'(me.widx));
          if (me.chk_idx >= 0)
            chk("hw_regs", 64'(hw_regs[(me.chk_idx-ROREGS)*RW +: RW]), 64'(me.chk_val));
        end
      end
      prev_rdy = reg_ready;
    end
  end

  initial begin
    logic [AW-1:0] a;
    int            idx, op;
    reset      = 1'b1;
    reg_read   = 1'b0;
    reg_write  = 1'b0;
    reg_addr   = '0;
    reg_wrdata = '0;
    reg_prot   = 2'b00;
    hw_status  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_ready", 64'(reg_ready), 64'd0);
    chk("rst_err", 64'(reg_err), 64'd0);
    chk("rst_rddata", 64'(reg_rddata), 64'd0);
    chk("rst_hw_wr", 64'(hw_wr), 64'd0);
    chk("rst_hw_wr_idx", 64'(hw_wr_idx), 64'd0);
    chk("rst_hw_regs_nonzero", 64'(|hw_regs), 64'd0);
    @(posedge clk);
    #1;

    // Directed cases
    access(1, 0, 64'h14, 32'h0, 2'b00, 1);
    access(0, 1, 64'h20, 32'hDEADBEEF, 2'b00, 1);
    access(1, 0, 64'h20, 32'h0, 2'b00, 1);
    hw_status[0 +: RW] = 32'h12345678;
    access(1, 0, 64'h0, 32'h0, 2'b00, 1);
    access(0, 1, 64'h0, 32'hCAFEF00D, 2'b00, 1);
    access(1, 0, 64'h800, 32'h0, 2'b00, 1);
    access(1, 0, 64'h22, 32'h0, 2'b00, 1);
    access(1, 1, 64'h40, 32'h55AA55AA, 2'b00, 1);
    access(0, 1, 64'h400, 32'hA5A5A5A5, 2'b00, 1);
    access(1, 0, 64'h400, 32'h0, 2'b00, 1);
    access(0, 1, 64'h400, 32'h5A5A5A5A, 2'b01, 1);
    access(1, 0, 64'h400, 32'h0, 2'b01, 1);
    access(0, 1, 64'h7FC, 32'h13579BDF, 2'b01, 1);
    access(1, 0, 64'h7FC, 32'h0, 2'b00, 1);
    access(1, 0, 64'h8000_0000_0000_0010, 32'h0, 2'b00, 1);

    // Randomized traffic biased toward a few indices for read-after-write hits
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0)
        hw_status = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       idx = $urandom_range(0, REGS-1);
        1:       idx = $urandom_range(REGS/2, REGS/2 + 7);
        default: idx = $urandom_range(0, 15);
      endcase
      a = AW'(idx) << 2;
      case ($urandom_range(0, 9))
        0: a = {$urandom, $urandom};
        1: a = a | AW'($urandom_range(1, 3));
        2: a = a | (64'd1 << $urandom_range(11, 63));
        default: ;
      endcase
      op = $urandom_range(0, 9);
      access(op < 5 || op == 9, op >= 5, a, $urandom, 2'($urandom_range(0, 3)), 1);
    end

    // Reset during the acknowledge cycle of a write
    access(0, 1, 64'h30, 32'h0BADF00D, 2'b01, 0);
    reset = 1'b1;
    #1;
    chk("rst_ack_ready_drop", 64'(reg_ready), 64'd0);
    chk("rst_ack_hw_wr_drop", 64'(hw_wr), 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    access(1, 0, 64'h30, 32'h0, 2'b00, 1);
    access(1, 0, 64'h20, 32'h0, 2'b00, 1);

    // Drain outstanding predictions
    for (int c = 0; c < 20 && q.size() != 0; c++) @(posedge clk);
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending responses, expected 0", q.size());
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_umi_regfile
`default_nettype wire

// File: doc/umi_regfile.md
# umi_regfile

Memory-mapped register bank that terminates the simple register interface produced by `umi_regif`, replacing the behavioural register array used in bench support logic. Accepts one read or write per handshake, decodes the word address, returns registered read data with an explicit `reg_ready` acknowledge and an error code, and exposes the read-write registers plus a write-notify pulse to hardware. The lowest `ROREGS` words are read-only mirrors of hardware status inputs.

## Interface
- `RW`, 32, register/data width in bits (power of two, ≥8)
- `AW`, 64, address width
- `REGS`, 512, total register words (power of two, ≥2)
- `ROREGS`, 4, number of read-only status words at indices 0..ROREGS-1 (0 ≤ ROREGS < REGS)

- `clk` in 1 — clock
- `reset` in 1 — asynchronous, active-high reset
- `reg_write` in 1 — write request, held until acknowledged
- `reg_read` in 1 — read request, held until acknowledged
- `reg_addr` in AW — byte address
- `reg_wrdata` in RW — write data
- `reg_prot` in 2 — protection attributes; bit0 = privileged
- `reg_rddata` out RW — read data, valid while `reg_ready`=1
- `reg_ready` out 1 — one-cycle acknowledge
- `reg_err` out 2 — 00 OK, 10 SLVERR, 11 DECERR; valid while `reg_ready`=1
- `hw_status` in ROREGS*RW — status word i at bits [i*RW +: RW]
- `hw_regs` out (REGS-ROREGS)*RW — flattened read-write register contents
- `hw_wr` out 1 — one-cycle pulse after a successful write
- `hw_wr_idx` out log2(REGS) — word index of last successful write

## Operation
- Word index = `reg_addr[2 +: log2(REGS)]`; byte offset = `reg_addr[1:0]`.
- FSM states IDLE, ACK. IDLE: if `reg_read` or `reg_write`, decode, perform access, latch response, go to ACK. ACK: drive `reg_ready`=1 for exactly one cycle, ignore request inputs, return to IDLE.
- Error priority (highest first): DECERR if any `reg_addr` bit ≥ 2+log2(REGS) set; SLVERR if `reg_read` and `reg_write` both high; SLVERR if byte offset ≠ 0; SLVERR on write to index < ROREGS; otherwise OK.
- Erroring accesses: no register modified, `hw_wr` not pulsed, `reg_rddata`=0.
- Reads: index < ROREGS returns `hw_status` sampled in the IDLE decode cycle; else stored register.
- Writes: full-word update of the register; `hw_wr` pulses in the ACK cycle with `hw_wr_idx`.
- Read-write registers and `hw_regs` reset to 0.

## Timing
- Reset values: `reg_ready`=0, `reg_err`=00, `reg_rddata`=0, `hw_wr`=0, `hw_wr_idx`=0, FSM=IDLE.
- Latency: request sampled at edge N, `reg_ready`/`reg_rddata`/`reg_err` high/valid for cycle N+1 only; written value visible on `hw_regs` from cycle N+1.
- Throughput: one access per 2 cycles; a request still asserted in the ACK cycle is the requester's next access only if held into the following IDLE cycle.
- Read of a register written in the previous access returns the new value.
- Reset asserted mid-access: FSM to IDLE immediately, pending acknowledge dropped, registers cleared; no partial write.

## Configuration
- `UMI_REGFILE_PROT_EN` defined: write with `reg_prot[0]`=0 to index ≥ REGS/2 returns SLVERR (priority just below read-only check), no update. Reads unaffected.
- Undefined: `reg_prot` ignored; all read-write indices writable.

## Structure
- Package `umi_regfile_pkg`: error code constants (OK, SLVERR, DECERR), FSM state enum.
- Sub-module `umi_regfile_dec`: combinational decode of address/op/prot to index and error code; core holds FSM and storage.

## Test plan
- Reset then read index 5 (addr 0x14) -> `reg_ready` one cycle later, `reg_rddata`=0, `reg_err`=00.
- Write 0xDEADBEEF to addr 0x20 then read 0x20 -> `hw_wr`=1 with `hw_wr_idx`=8; read returns 0xDEADBEEF, err 00.
- `hw_status[0]`=0x12345678, read addr 0x0 -> 0x12345678; write addr 0x0 -> `reg_err`=10, no `hw_wr`.
- Read addr 0x800 (REGS=512) -> `reg_err`=11, `reg_rddata`=0; read addr 0x22 -> `reg_err`=10.
- With `UMI_REGFILE_PROT_EN`, write addr 0x400 with `reg_prot`=00 -> err 10, value unchanged; with `reg_prot`=01 -> err 00, value updated.
- Assert `reset` in the ACK cycle of a write -> `reg_ready` drops to 0, register reads back 0 after reset.
